// File: rtl/arcfour_pkg.sv
// Shared types and helpers for the ARCFOUR encryption engine.
// The engine is byte-oriented: S-box, key and message words are 8 bits.
package arcfour_pkg;

   localparam int BYTE_W     = 8;
   localparam int SBOX_DEPTH = 2**BYTE_W;
   localparam int KEY_MAX    = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_SHUFFLE,
      ST_PRGA,
      ST_DONE
   } enc_state_t;

   typedef logic [KEY_MAX-1:0][BYTE_W-1:0] key_bus_t;

   // The key is stored most-significant-byte first, so byte 0 is key[key_len-1].
   function automatic logic [BYTE_W-1:0] keybyte(input key_bus_t key,
                                                 input int unsigned key_len,
                                                 input int unsigned idx);
      return key[4'(key_len - 1 - idx)];
   endfunction

endpackage

// File: rtl/arcfour_encryptor_if.sv
// Memory-side bus of the encryptor: S-box RAM, plaintext memory, ciphertext RAM.
// All memories have one cycle of read latency.
interface arcfour_encryptor_if #(
   parameter int RAM_WIDTH          = 8,
   parameter int MESSAGE_LOG_LENGTH = 5
);
   logic                          sWren;
   logic [RAM_WIDTH-1:0]          sAddr;
   logic [RAM_WIDTH-1:0]          sIn;
   logic [RAM_WIDTH-1:0]          sOut;
   logic [MESSAGE_LOG_LENGTH-1:0] pAddr;
   logic [RAM_WIDTH-1:0]          pOut;
   logic                          cWren;
   logic [MESSAGE_LOG_LENGTH-1:0] cAddr;
   logic [RAM_WIDTH-1:0]          cIn;

   modport master (
      output sWren, sAddr, sIn, pAddr, cWren, cAddr, cIn,
      input  sOut, pOut
   );

   modport slave (
      input  sWren, sAddr, sIn, pAddr, cWren, cAddr, cIn,
      output sOut, pOut
   );
endinterface

// File: rtl/edge_detector.sv
// Rising-edge detector: rise is high for the cycle in which sig is high
// and was low at the previous clock edge.
module edge_detector (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic rise
);
   logic prev;

   always_ff @(posedge clk) begin
      if (reset) prev <= 1'b0;
      else       prev <= sig;
   end

   assign rise = sig & ~prev;
endmodule

// File: rtl/arcfour_encryptor.sv
// RC4 encryption engine: initialises and key-schedules its S-box RAM, then
// XORs the keystream with the plaintext memory into the ciphertext RAM.
module arcfour_encryptor
   import arcfour_pkg::*;
#(
   parameter int RAM_WIDTH          = 8,
   parameter int KEY_LENGTH         = 3,
   parameter int MESSAGE_LENGTH     = 32,
   parameter int MESSAGE_LOG_LENGTH = 5
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0] key,
   arcfour_encryptor_if.master                  mem,
   output logic                                 busy,
   output logic                                 done
);
   localparam int KEY_W = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

   typedef logic [RAM_WIDTH-1:0] word_t;

   enc_state_t                          state, state_n;
   logic [2:0]                          phase, phase_n;
   word_t                               i_q, j_q;
   logic [MESSAGE_LOG_LENGTH-1:0]       k_q;
   logic [KEY_W-1:0]                    kidx_q;
   logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0] key_q;
   word_t                               si_q, sj_q, pk_q;
   key_bus_t                            key_bus;
   word_t                               kb, j_sum;
   logic                                start_rise, last_i, last_k;

   edge_detector u_start_edge (
      .clk   (clk),
      .reset (reset),
      .sig   (start),
      .rise  (start_rise)
   );

   always_comb begin
      key_bus                 = '0;
      key_bus[KEY_LENGTH-1:0] = key_q;
   end

   assign kb     = word_t'(keybyte(key_bus, KEY_LENGTH, 32'(kidx_q)));
   // The key byte only contributes during the key schedule; PRGA reuses the adder.
   assign j_sum  = j_q + mem.sOut + ((state == ST_SHUFFLE) ? kb : '0);
   assign last_i = (i_q == '1);
   assign last_k = (k_q == MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         phase  <= '0;
         i_q    <= '0;
         j_q    <= '0;
         k_q    <= '0;
         kidx_q <= '0;
         key_q  <= '0;
      end else begin
         state <= state_n;
         phase <= phase_n;
         case (state)
            ST_IDLE: begin
               if (start_rise) begin
                  key_q  <= key;
                  i_q    <= '0;
                  j_q    <= '0;
                  k_q    <= '0;
                  kidx_q <= '0;
               end
            end
            ST_INIT: i_q <= i_q + 1'b1;
            ST_SHUFFLE: begin
               if (phase == 3'd1) j_q <= j_sum;
               if (phase == 3'd3) begin
                  i_q    <= i_q + 1'b1;
                  kidx_q <= (kidx_q == KEY_W'(KEY_LENGTH - 1)) ? '0 : kidx_q + 1'b1;
                  if (last_i) j_q <= '0;
               end
            end
            ST_PRGA: begin
               if (phase == 3'd0) i_q <= i_q + 1'b1;
               if (phase == 3'd1) j_q <= j_sum;
               if (phase == 3'd5) k_q <= k_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Data registers: operands captured from the memories, no reset needed.
   always_ff @(posedge clk) begin
      if ((state == ST_SHUFFLE || state == ST_PRGA) && phase == 3'd1) begin
         si_q <= mem.sOut;
         pk_q <= mem.pOut;
      end
      if (state == ST_PRGA && phase == 3'd2) sj_q <= mem.sOut;
   end

   always_comb begin
      state_n   = state;
      phase_n   = phase;
      mem.sWren = 1'b0;
      mem.sAddr = '0;
      mem.sIn   = '0;
      mem.pAddr = '0;
      mem.cWren = 1'b0;
      mem.cAddr = '0;
      mem.cIn   = '0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            phase_n = '0;
            if (start_rise) state_n = ST_INIT;
         end
         ST_INIT: begin
            busy      = 1'b1;
            mem.sWren = 1'b1;
            mem.sAddr = i_q;
            mem.sIn   = i_q;
            phase_n   = '0;
            if (last_i) state_n = ST_SHUFFLE;
         end
         ST_SHUFFLE: begin
            busy = 1'b1;
            case (phase)
               3'd0: begin
                  mem.sAddr = i_q;
                  phase_n   = 3'd1;
               end
               3'd1: begin
                  mem.sAddr = j_sum;
                  phase_n   = 3'd2;
               end
               3'd2: begin
                  mem.sWren = 1'b1;
                  mem.sAddr = i_q;
                  mem.sIn   = mem.sOut;
                  phase_n   = 3'd3;
               end
               default: begin
                  mem.sWren = 1'b1;
                  mem.sAddr = j_q;
                  mem.sIn   = si_q;
                  phase_n   = 3'd0;
                  if (last_i) state_n = ST_PRGA;
               end
            endcase
         end
         ST_PRGA: begin
            busy = 1'b1;
            case (phase)
               3'd0: begin
                  mem.sAddr = i_q + 1'b1;
                  mem.pAddr = k_q;
                  phase_n   = 3'd1;
               end
               3'd1: begin
                  mem.sAddr = j_sum;
                  phase_n   = 3'd2;
               end
               3'd2: begin
                  mem.sWren = 1'b1;
                  mem.sAddr = i_q;
                  mem.sIn   = mem.sOut;
                  phase_n   = 3'd3;
               end
               3'd3: begin
                  mem.sWren = 1'b1;
                  mem.sAddr = j_q;
                  mem.sIn   = si_q;
                  phase_n   = 3'd4;
               end
               3'd4: begin
                  // Post-swap S[i]+S[j] equals the pre-swap sum.
                  mem.sAddr = si_q + sj_q;
                  phase_n   = 3'd5;
               end
               default: begin
                  mem.cWren = 1'b1;
                  mem.cAddr = k_q;
                  mem.cIn   = mem.sOut ^ pk_q;
                  phase_n   = 3'd0;
                  if (last_k) state_n = ST_DONE;
               end
            endcase
         end
         ST_DONE: begin
            done    = 1'b1;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end
endmodule

// File: doc/arcfour_encryptor.md
Name: arcfour_encryptor

Overview:
- RC4 (ARCFOUR) encryption engine. It takes an externally supplied key and a plaintext held in a synchronous message memory, and writes the ciphertext into an output memory.
- It drives its own S-box RAM through the standard single-port memory interface (S-RAM, P-memory, C-RAM) used by the decryption datapath.
- It provides the test and loopback source for the brute-force decryptor: any ciphertext it writes must decrypt under the same key.

Parameters:
- RAM_WIDTH, 8, byte width; the S-box has 2**RAM_WIDTH entries.
- KEY_LENGTH, 3, key length in bytes.
- MESSAGE_LENGTH, 32, number of plaintext/ciphertext bytes.
- MESSAGE_LOG_LENGTH, 5, address width of the message memories; 2**MESSAGE_LOG_LENGTH >= MESSAGE_LENGTH.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  rising edge launches an encryption
- key  in  [KEY_LENGTH-1:0][RAM_WIDTH-1:0]  secret key; key[KEY_LENGTH-1] is key byte 0
- sWren  out  1  S-RAM write enable
- sAddr  out  RAM_WIDTH  S-RAM address
- sIn  out  RAM_WIDTH  S-RAM write data
- sOut  in  RAM_WIDTH  S-RAM read data
- pAddr  out  MESSAGE_LOG_LENGTH  plaintext memory address
- pOut  in  RAM_WIDTH  plaintext read data
- cWren  out  1  ciphertext RAM write enable
- cAddr  out  MESSAGE_LOG_LENGTH  ciphertext RAM address
- cIn  out  RAM_WIDTH  ciphertext write data
- busy  out  1  high from the first cycle after the start edge until done
- done  out  1  one-cycle pulse when the last ciphertext byte has been written

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high.
- Reset values: state IDLE, every output 0, all counters 0, key register 0.
- Memory timing: every memory has 1-cycle read latency. An address presented in cycle N returns data on the Out port in cycle N+1. A write commits at the clock edge while wren is high.
- Start detection: start is edge-detected with the existing edge_detector. A rising edge is acted on only in IDLE, and key is latched into an internal register on that cycle. Edges while busy are ignored; key changes while busy have no effect.
- State machine: IDLE -> INIT -> SHUFFLE -> PRGA -> DONE -> IDLE.
- INIT: writes S[i]=i for i=0..2**RAM_WIDTH-1, one write per cycle (256 cycles at default width).
- SHUFFLE: for i=0..255:
  - j = (j + S[i] + keybyte[i mod KEY_LENGTH]) mod 256, with j starting at 0.
  - swap S[i] and S[j] (two writes; the value read for S[j] is used even when i==j).
  - i mod KEY_LENGTH comes from a wrapping counter, not a divider.
  - At most 6 cycles per iteration.
- PRGA: i=0, j=0 on entry. For k=0..MESSAGE_LENGTH-1:
  - i=(i+1) mod 256, then j=(j+S[i]) mod 256.
  - swap S[i] and S[j].
  - f = S[(S[i]+S[j]) mod 256], using the post-swap values.
  - c[k] = f XOR p[k], written at cAddr=k with cWren for exactly one cycle.
  - At most 8 cycles per byte; the p[k] read may overlap the S reads.
- Arithmetic: all index arithmetic is RAM_WIDTH bits and wraps modulo 2**RAM_WIDTH with no carry out. Counter i wraps 255->0 inside PRGA.
- DONE: lasts one cycle; done=1, busy=0 in the same cycle. The next cycle is IDLE.
- Write exclusivity: sWren and cWren are never high in the same cycle. No memory write occurs in IDLE or DONE.
- Reset mid-operation: reset takes effect at the next edge. The block returns to IDLE with no further writes and no done pulse. Partial S or C contents are left as-is.
- Back-to-back runs: a start edge arriving in the DONE cycle is dropped. A start edge in the first IDLE cycle after DONE is accepted.
- Total latency: start edge to done is at most 256 + 6*256 + 8*MESSAGE_LENGTH + 4 cycles.

Decomposition:
- Package arcfour_pkg holds:
  - the encryptor state enum;
  - SBOX_DEPTH = 2**RAM_WIDTH;
  - key-byte select function keybyte(key, idx) returning key[KEY_LENGTH-1-idx].
- The existing edge_detector is reused.
- Everything else stays in one module; no further sub-module is warranted.

Test Plan:
- KEY_LENGTH=3, key=0x4B6579 ("Key"), MESSAGE_LENGTH=9, P="Plaintext" -> C = BB F3 16 E8 D9 40 AF 0A D3; exactly one done pulse.
- KEY_LENGTH=4, key=0x57696B69 ("Wiki"), MESSAGE_LENGTH=5, P="pedia" -> C = 10 21 BF 04 20.
- Key 0x4B6579, C from scenario 1 loaded as P -> output equals "Plaintext" (involution check). Also decrypt that ciphertext with the existing decryptor via its switch-key path; it must report success.
- Reset asserted 100 cycles into SHUFFLE -> next cycle busy=0, sWren=0, cWren=0, no done. A fresh start then reproduces the scenario 1 result.
- Start pulsed again mid-PRGA and key changed while busy -> result still equals scenario 1, and only one done pulse.
- After INIT with tap-read of S-RAM: S[i]=i for all 256 entries. Measured start-to-done latency is within the stated bound.
